button_event_decoder: RTL
=========================

Name: button_event_decoder

Overview:
- Consumes the clean level from the debouncer (same clock domain) and classifies each press into a one-cycle event: short press, long press or double click.
- Also emits raw press and release edge pulses.
- Sits between the debouncer output and the control/register logic that acts on user button input.

Parameters:
- long_press_clks, 1000, cycles a press must be held before long_press fires (min 2).
- dclick_gap_clks, 300, maximum released cycles between two presses for a double click (min 2).
- cnt_width, 16, hold/gap counter width; must hold max(long_press_clks, dclick_gap_clks)-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- db_in  input  1  debounced button level, synchronous to clk, 1 = pressed.
- press_pulse  output  1  one-cycle pulse on each rising edge of db_in.
- release_pulse  output  1  one-cycle pulse on each falling edge of db_in.
- short_press  output  1  one-cycle pulse: single short press confirmed.
- long_press  output  1  one-cycle pulse: hold threshold reached.
- double_click  output  1  one-cycle pulse: second press released within gap.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. While rst_n=0: all outputs 0, FSM in IDLE, counter 0, edge register db_q 0.
- Edge detection: db_q <= db_in each cycle. rise = db_in & ~db_q; fall = ~db_in & db_q.
- All outputs are registered. Every pulse is high for exactly 1 cycle, in the cycle after the edge at which rise/fall/terminal count is evaluated.
- press_pulse and release_pulse fire on every rise/fall, independent of FSM state.
- A held db_in=1 at reset release counts as a rise, so press_pulse appears in the 2nd cycle after deassertion.
- FSM states: IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESSED.
- IDLE:
  - rise -> PRESSED, counter <= 0.
- PRESSED (counter increments each cycle):
  - fall -> WAIT_SECOND, counter <= 0.
  - Else counter == long_press_clks-1 -> LONG_HELD, long_press pulse.
  - fall has priority over the terminal count in the same cycle.
  - long_press rises exactly long_press_clks cycles after press_pulse rises.
- LONG_HELD:
  - fall -> IDLE.
  - No short_press or double_click is ever generated for this press.
- WAIT_SECOND (counter increments):
  - rise -> SECOND_PRESSED.
  - Else counter == dclick_gap_clks-1 -> IDLE, short_press pulse.
  - rise has priority over the terminal count.
  - short_press rises exactly dclick_gap_clks cycles after release_pulse rises.
- SECOND_PRESSED:
  - fall -> IDLE, double_click pulse, coincident with that release_pulse.
  - No long_press timing applies in this state; an arbitrarily long second hold still yields double_click.
- Counter:
  - Saturates; never wraps.
  - Cleared on every state change.
  - Held at 0 in IDLE, LONG_HELD and SECOND_PRESSED.
- Mutual exclusion: at most one of short_press, long_press, double_click is high in any cycle.
- busy = (state != IDLE), registered with the state.
- Reset mid-operation: immediate return to reset values. No event pulse is emitted for the interrupted press.

Decomposition:
- Shared package/include button_event_pkg holds:
  - FSM state encodings (3-bit localparams S_IDLE..S_SECOND_PRESSED).
  - Default timing constants for the debounce/event chain.
- One sub-module: edge_detect (clk, rst_n, din -> rise, fall, registered db_q). It is reusable for other debounced inputs.
- FSM and counter stay in button_event_decoder.

Test Plan (long_press_clks=8, dclick_gap_clks=4, cnt_width=4):
- Short press: db_in high 3 cycles then low -> press_pulse, release_pulse, short_press 4 cycles after release_pulse; long_press and double_click stay 0.
- Long press: db_in high 20 cycles -> long_press exactly 8 cycles after press_pulse, once only; on release, release_pulse only; no short_press.
- Double click: high 2, low 2, high 2, low -> two press_pulse, double_click coincident with second release_pulse; short_press never asserted.
- Boundary priority:
  - Second rise in the WAIT_SECOND terminal-count cycle -> double_click path, no short_press.
  - Fall in the PRESSED terminal cycle -> short_press path, no long_press.
- Reset mid-press: assert rst_n=0 at PRESSED count 5 -> all outputs 0 asynchronously; after deassertion with db_in=0, no pulses for 20 cycles and busy=0.
- db_in=1 through reset release -> press_pulse in 2nd cycle after deassertion; long_press 8 cycles later.

Source files
------------

// File: rtl/button_event_pkg.sv
// Shared definitions for the button event chain: FSM state encodings and
// default timing constants used by the debounce/event decoder blocks.
package button_event_pkg;

    localparam logic [2:0] S_IDLE           = 3'd0;
    localparam logic [2:0] S_PRESSED        = 3'd1;
    localparam logic [2:0] S_LONG_HELD      = 3'd2;
    localparam logic [2:0] S_WAIT_SECOND    = 3'd3;
    localparam logic [2:0] S_SECOND_PRESSED = 3'd4;

    typedef enum logic [2:0] {
        IDLE           = S_IDLE,
        PRESSED        = S_PRESSED,
        LONG_HELD      = S_LONG_HELD,
        WAIT_SECOND    = S_WAIT_SECOND,
        SECOND_PRESSED = S_SECOND_PRESSED
    } btn_state_t;

    localparam int DEF_LONG_PRESS_CLKS = 1000;
    localparam int DEF_DCLICK_GAP_CLKS = 300;
    localparam int DEF_CNT_WIDTH       = 16;

endpackage

// File: rtl/button_event_decoder_if.sv
// Button level in, classified event pulses out. The slave side is the decoder;
// the master side is whoever supplies the debounced level and consumes events.
interface button_event_decoder_if;

    logic db_in;
    logic press_pulse;
    logic release_pulse;
    logic short_press;
    logic long_press;
    logic double_click;
    logic busy;

    modport master (
        output db_in,
        input  press_pulse, release_pulse, short_press, long_press, double_click, busy
    );

    modport slave (
        input  db_in,
        output press_pulse, release_pulse, short_press, long_press, double_click, busy
    );

endinterface

// File: rtl/button_event_decoder_edge_detect.sv
// Rise/fall detector for a level already synchronous to clk; reusable for any
// debounced input. Edges are combinational off the one-cycle-delayed level.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic db_q;

    // A level held high through reset release shows up as a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) db_q <= 1'b0;
        else        db_q <= din;
    end

    assign rise = din & ~db_q;
    assign fall = ~din & db_q;

endmodule

// File: rtl/button_event_decoder.sv
// Classifies each debounced press into short press, long press or double click,
// plus raw press/release edge pulses. All outputs registered, one cycle wide.
module button_event_decoder
    import button_event_pkg::*;
#(
    parameter int long_press_clks = DEF_LONG_PRESS_CLKS,
    parameter int dclick_gap_clks = DEF_DCLICK_GAP_CLKS,
    parameter int cnt_width       = DEF_CNT_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    button_event_decoder_if.slave bus
);

    localparam logic [cnt_width-1:0] LONG_TC = cnt_width'(long_press_clks - 1);
    localparam logic [cnt_width-1:0] GAP_TC  = cnt_width'(dclick_gap_clks - 1);

    logic                 rise;
    logic                 fall;
    btn_state_t           state;
    logic [cnt_width-1:0] cnt;

    function automatic logic [cnt_width-1:0] sat_inc(input logic [cnt_width-1:0] v);
        return (v == {cnt_width{1'b1}}) ? v : v + cnt_width'(1);
    endfunction

    edge_detect u_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (bus.db_in),
        .rise (rise),
        .fall (fall)
    );

    // Edge pulses are state-independent; event pulses default low and are set
    // only on the transition that confirms them, so they are mutually exclusive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            cnt               <= '0;
            bus.press_pulse   <= 1'b0;
            bus.release_pulse <= 1'b0;
            bus.short_press   <= 1'b0;
            bus.long_press    <= 1'b0;
            bus.double_click  <= 1'b0;
            bus.busy          <= 1'b0;
        end else begin
            bus.press_pulse   <= rise;
            bus.release_pulse <= fall;
            bus.short_press   <= 1'b0;
            bus.long_press    <= 1'b0;
            bus.double_click  <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rise) begin
                        state    <= PRESSED;
                        bus.busy <= 1'b1;
                    end
                end
                PRESSED: begin
                    if (fall) begin
                        state <= WAIT_SECOND;
                        cnt   <= '0;
                    end else if (cnt == LONG_TC) begin
                        state          <= LONG_HELD;
                        cnt            <= '0;
                        bus.long_press <= 1'b1;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                LONG_HELD: begin
                    cnt <= '0;
                    if (fall) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                WAIT_SECOND: begin
                    if (rise) begin
                        state <= SECOND_PRESSED;
                        cnt   <= '0;
                    end else if (cnt == GAP_TC) begin
                        state           <= IDLE;
                        cnt             <= '0;
                        bus.busy        <= 1'b0;
                        bus.short_press <= 1'b1;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                SECOND_PRESSED: begin
                    cnt <= '0;
                    if (fall) begin
                        state            <= IDLE;
                        bus.busy         <= 1'b0;
                        bus.double_click <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
